// File: rtl/mem_stage_mem_ctrl.sv
// MEM-stage memory controller: turns EX/MEM load/store requests into a single
// outstanding req/ack bus transaction, stalls the pipeline and returns load data.
module mem_stage_mem_ctrl #(
  parameter int ADDR_W      = 5,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MEM_re,
  input  logic              MEM_we,
  input  logic              MEM_use_sprite_mem,
  input  logic [ADDR_W-1:0] MEM_addr,
  input  logic [DATA_W-1:0] MEM_data,
  input  logic [DATA_W-1:0] MEM_sprite_data,
  output logic              bus_req,
  output logic              bus_we,
  output logic              bus_sprite,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              mem_stall,
  output logic [DATA_W-1:0] load_data,
  output logic              load_valid,
  output logic              bus_err
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  localparam int          CNT_W   = 10;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             req;

  assign req = MEM_re | MEM_we;

  // Hold the pipeline while a request waits to launch or is in flight; never during reset.
  assign mem_stall = ~rst & (((state == IDLE) & req) | (state == REQ));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_sprite <= 1'b0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      load_data  <= '0;
      load_valid <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      load_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            bus_addr   <= MEM_addr;
            bus_we     <= MEM_we;
            bus_sprite <= MEM_use_sprite_mem;
            bus_wdata  <= MEM_use_sprite_mem ? MEM_sprite_data : MEM_data;
            bus_req    <= 1'b1;
            cnt        <= '0;
            state      <= REQ;
          end
        end
        REQ: begin
          // An ack arriving on the last allowed cycle still completes normally.
          if (bus_ack) begin
            bus_req <= 1'b0;
            state   <= DONE;
            if (!bus_we) begin
              load_data  <= bus_rdata;
              load_valid <= 1'b1;
            end
          end else if (cnt == CNT_MAX) begin
            bus_req <= 1'b0;
            bus_err <= 1'b1;
            state   <= DONE;
            if (!bus_we) begin
              load_data  <= '0;
              load_valid <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          cnt   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_mem_ctrl.sv
// Self-checking bench for mem_stage_mem_ctrl: table of directed transactions
// plus hand-written reset-mid-request and stray-ack sequences.
module tb_mem_stage_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        MEM_re, MEM_we, MEM_use_sprite_mem;
  logic [4:0]  MEM_addr;
  logic [31:0] MEM_data, MEM_sprite_data;
  logic        bus_req, bus_we, bus_sprite;
  logic [4:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        mem_stall;
  logic [31:0] load_data;
  logic        load_valid, bus_err;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  int rises  = 0;
  logic prev_req = 1'b0;

  mem_stage_mem_ctrl #(.ADDR_W(5), .DATA_W(32), .TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst(rst),
    .MEM_re(MEM_re), .MEM_we(MEM_we), .MEM_use_sprite_mem(MEM_use_sprite_mem),
    .MEM_addr(MEM_addr), .MEM_data(MEM_data), .MEM_sprite_data(MEM_sprite_data),
    .bus_req(bus_req), .bus_we(bus_we), .bus_sprite(bus_sprite),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .mem_stall(mem_stall), .load_data(load_data),
    .load_valid(load_valid), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Count bus transactions launched, to catch duplicates.
  always @(negedge clk) begin
    if (bus_req && !prev_req) rises++;
    prev_req = bus_req;
  end

  typedef struct {
    logic        re, we, sprite;
    logic [4:0]  addr;
    logic [31:0] data, sdata;
    int          delay;
    logic [31:0] rdata;
    logic        exp_we;
    logic [31:0] exp_wdata;
    int          exp_stall, exp_reqc;
    logic        exp_lv;
    logic [31:0] exp_ld;
    logic        exp_err;
  } vec_t;

  vec_t vecs [7];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic dropInputs();
    MEM_re = 0; MEM_we = 0; MEM_use_sprite_mem = 0;
    MEM_addr = '0; MEM_data = '0; MEM_sprite_data = '0;
  endtask

  task automatic applyStimulus(input vec_t v, input string tag, output int rise_cyc);
    int  stall_n = 0;
    int  reqc    = 0;
    bit  done    = 0;
    rise_cyc = -1;
    @(negedge clk);
    checkOutput({tag, ".lv_before"}, {31'b0, load_valid}, 32'd0);
    MEM_re = v.re; MEM_we = v.we; MEM_use_sprite_mem = v.sprite;
    MEM_addr = v.addr; MEM_data = v.data; MEM_sprite_data = v.sdata;
    for (int c = 0; c < 100 && !done; c++) begin
      #1;
      if (mem_stall) stall_n++;
      if (bus_req) begin
        reqc++;
        if (reqc == 1) begin
          rise_cyc = cyc;
          checkOutput({tag, ".addr"},   {27'b0, bus_addr},   {27'b0, v.addr});
          checkOutput({tag, ".we"},     {31'b0, bus_we},     {31'b0, v.exp_we});
          checkOutput({tag, ".sprite"}, {31'b0, bus_sprite}, {31'b0, v.sprite});
          checkOutput({tag, ".wdata"},  bus_wdata,           v.exp_wdata);
        end
        bus_ack   = (reqc == v.delay + 1);
        bus_rdata = bus_ack ? v.rdata : 32'hDEAD_0000 + reqc;
      end else if (reqc > 0) begin
        done    = 1;
        bus_ack = 0;
        checkOutput({tag, ".stall_cycles"}, stall_n,                 v.exp_stall);
        checkOutput({tag, ".req_cycles"},   reqc,                    v.exp_reqc);
        checkOutput({tag, ".stall_done"},   {31'b0, mem_stall},      32'd0);
        checkOutput({tag, ".load_valid"},   {31'b0, load_valid},     {31'b0, v.exp_lv});
        checkOutput({tag, ".load_data"},    load_data,               v.exp_ld);
        checkOutput({tag, ".bus_err"},      {31'b0, bus_err},        {31'b0, v.exp_err});
        dropInputs();
      end else begin
        bus_ack = 0;
      end
      if (!done) @(negedge clk);
    end
    if (!done) begin
      checkOutput({tag, ".completed"}, 32'd0, 32'd1);
      dropInputs();
      bus_ack = 0;
    end
  endtask

  task automatic resetMidReq();
    @(negedge clk);
    MEM_re = 1; MEM_addr = 5'h09;
    @(negedge clk);
    #1 checkOutput("rst.req1", {31'b0, bus_req}, 32'd1);
    @(negedge clk);
    #1 checkOutput("rst.req2", {31'b0, bus_req}, 32'd1);
    rst = 1; bus_ack = 1; bus_rdata = 32'hFFFF_FFFF;
    #1 checkOutput("rst.stall_in_rst", {31'b0, mem_stall}, 32'd0);
    @(negedge clk);
    #1;
    checkOutput("rst.bus_req",    {31'b0, bus_req},    32'd0);
    checkOutput("rst.bus_we",     {31'b0, bus_we},     32'd0);
    checkOutput("rst.bus_sprite", {31'b0, bus_sprite}, 32'd0);
    checkOutput("rst.bus_addr",   {27'b0, bus_addr},   32'd0);
    checkOutput("rst.bus_wdata",  bus_wdata,           32'd0);
    checkOutput("rst.load_data",  load_data,           32'd0);
    checkOutput("rst.load_valid", {31'b0, load_valid}, 32'd0);
    checkOutput("rst.bus_err",    {31'b0, bus_err},    32'd0);
    rst = 0; bus_ack = 0; dropInputs();
    #1 checkOutput("rst.stall_after", {31'b0, mem_stall}, 32'd0);
    @(negedge clk);
    #1 checkOutput("rst.no_relaunch", {31'b0, bus_req}, 32'd0);
  endtask

  initial begin
    int r2, r3, rtmp;
    vecs[0] = '{1, 0, 0, 5'h0A, 32'h0, 32'h0, 0, 32'h1234_5678,
                0, 32'h0, 2, 1, 1, 32'h1234_5678, 0};
    vecs[1] = '{0, 1, 1, 5'h1F, 32'h0, 32'hCAFE_F00D, 3, 32'h0,
                1, 32'hCAFE_F00D, 5, 4, 0, 32'h1234_5678, 0};
    vecs[2] = '{1, 0, 0, 5'h01, 32'h0, 32'h0, 0, 32'h1111_1111,
                0, 32'h0, 2, 1, 1, 32'h1111_1111, 0};
    vecs[3] = '{0, 1, 0, 5'h02, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 0, 32'h0,
                1, 32'hA5A5_A5A5, 2, 1, 0, 32'h1111_1111, 0};
    vecs[4] = '{1, 0, 0, 5'h07, 32'h0, 32'h0, 255, 32'h0,
                0, 32'h0, 5, 4, 1, 32'h0, 1};
    vecs[5] = '{1, 0, 1, 5'h03, 32'h0, 32'h0, 1, 32'h0BAD_BEEF,
                0, 32'h0, 3, 2, 1, 32'h0BAD_BEEF, 1};
    vecs[6] = '{1, 1, 0, 5'h04, 32'h0000_0055, 32'hFFFF_0000, 0, 32'h9999_9999,
                1, 32'h0000_0055, 2, 1, 0, 32'h0, 0};

    rst = 1; bus_ack = 0; bus_rdata = '0;
    dropInputs();
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset.bus_req",    {31'b0, bus_req},    32'd0);
    checkOutput("reset.bus_addr",   {27'b0, bus_addr},   32'd0);
    checkOutput("reset.load_data",  load_data,           32'd0);
    checkOutput("reset.load_valid", {31'b0, load_valid}, 32'd0);
    checkOutput("reset.bus_err",    {31'b0, bus_err},    32'd0);
    checkOutput("reset.mem_stall",  {31'b0, mem_stall},  32'd0);
    rst = 0;

    r2 = 0; r3 = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i], $sformatf("v%0d", i), rtmp);
      if (i == 2) r2 = rtmp;
      if (i == 3) r3 = rtmp;
    end
    checkOutput("b2b.spacing", r3 - r2, 32'd3);

    resetMidReq();

    applyStimulus(vecs[6], "v6", rtmp);

    // Stray ack in IDLE must be ignored.
    @(negedge clk);
    bus_ack = 1; bus_rdata = 32'h7777_7777;
    @(negedge clk);
    #1;
    checkOutput("stray.bus_req",    {31'b0, bus_req},    32'd0);
    checkOutput("stray.mem_stall",  {31'b0, mem_stall},  32'd0);
    checkOutput("stray.load_valid", {31'b0, load_valid}, 32'd0);
    checkOutput("stray.load_data",  load_data,           32'd0);
    bus_ack = 0;
    @(negedge clk);
    #1;
    checkOutput("stray.bus_req2",    {31'b0, bus_req},    32'd0);
    checkOutput("stray.load_valid2", {31'b0, load_valid}, 32'd0);
    checkOutput("txn_count", rises, 32'd8);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/mem_stage_mem_ctrl.md
Name: mem_stage_mem_ctrl

Overview:
- MEM-stage responder for the request fields the EX/MEM pipeline register presents: read enable, write enable, address, store data and sprite-memory select.
- Converts a qualifying request into a single-outstanding req/ack transaction on the data-memory bus.
- Stalls the pipeline until that transaction completes.
- Returns load data to MEM/WB and holds it stable.

Parameters:
- ADDR_W, 5, width of MEM_addr and bus_addr
- DATA_W, 32, width of store/load data
- TIMEOUT_CYC, 64, cycles in REQ without bus_ack before abort; legal range 1..1023

Ports:
- clk  in  1  system clock; only clock
- rst  in  1  synchronous, active-high reset
- MEM_re  in  1  load request from EX/MEM register
- MEM_we  in  1  store request from EX/MEM register
- MEM_use_sprite_mem  in  1  1 = target sprite memory, 0 = data memory
- MEM_addr  in  ADDR_W  request address
- MEM_data  in  DATA_W  store data, data memory
- MEM_sprite_data  in  DATA_W  store data, sprite memory
- bus_req  out  1  transaction request, registered
- bus_we  out  1  1 = write, registered
- bus_sprite  out  1  memory select, registered
- bus_addr  out  ADDR_W  registered address
- bus_wdata  out  DATA_W  registered write data
- bus_ack  in  1  one-cycle completion from memory
- bus_rdata  in  DATA_W  read data; valid when bus_ack=1
- mem_stall  out  1  combinational hold to pipeline (drives hlt)
- load_data  out  DATA_W  registered load result to MEM/WB
- load_valid  out  1  one-cycle pulse: load_data updated
- bus_err  out  1  sticky timeout flag

Behaviour:
- Reset: applies on any clk edge with rst=1, including mid-transaction.
  - bus_req, bus_we, bus_sprite, bus_addr, bus_wdata, load_data, load_valid, bus_err all 0.
  - FSM to IDLE; timeout counter 0.
  - A pending bus_ack in the reset cycle is ignored.
- Request definition: req = MEM_re | MEM_we.
  - If both are 1, the request is treated as a write (bus_we=1). No read data is returned and load_valid is not pulsed.
- FSM states are IDLE, REQ, DONE.
- IDLE:
  - If req=1: capture addr, we, sprite select and wdata into the bus registers, then go to REQ.
  - wdata = MEM_sprite_data if MEM_use_sprite_mem else MEM_data.
- REQ:
  - bus_req=1; all other bus outputs stay stable.
  - Counter increments each cycle.
  - On bus_ack=1: go to DONE with bus_req=0 next cycle. For a read, load_data<=bus_rdata and load_valid<=1.
  - If the counter reaches TIMEOUT_CYC-1 without ack: go to DONE and set bus_err<=1. For a read, load_data<=0 and load_valid<=1.
- DONE: bus_req=0; counter clears; unconditionally go to IDLE.
  - The pipeline advances on the DONE edge, so a new request is seen in IDLE the following cycle. The same instruction is never relaunched.
- mem_stall = (IDLE & req) | REQ. It is 0 in DONE and 0 during reset.
- Latency: request visible in cycle 0, bus_ack in the first REQ cycle (cycle 1), DONE in cycle 2.
  - mem_stall is high in cycles 0–1.
  - Minimum overhead is 2 stall cycles; each extra ack delay adds 1 cycle.
- Back-to-back requests: minimum spacing is 3 cycles (IDLE, REQ, DONE).
- load_data holds its value until the next read completes. load_valid is high for exactly one cycle, in DONE.
- bus_ack while in IDLE or DONE is ignored and causes no state or data change.
- Once set, bus_err stays 1 until reset; later requests still operate normally.
- No request (re=we=0): FSM stays in IDLE, mem_stall=0, bus outputs hold their last values with bus_req=0.

Test Plan:
- Read, immediate ack: re=1, addr=5'h0A, sprite=0; ack in first REQ cycle with rdata=32'h1234_5678.
  - Expect: bus_req high 1 cycle, bus_addr=0A, bus_we=0, mem_stall high exactly 2 cycles.
  - Expect: load_data=1234_5678 with load_valid pulse in the DONE cycle.
- Sprite write, delayed ack: we=1, sprite=1, MEM_sprite_data=32'hCAFE_F00D, MEM_data=32'h0; ack 3 cycles into REQ.
  - Expect: bus_wdata=CAFE_F00D, bus_sprite=1, mem_stall high 5 cycles.
  - Expect: no load_valid; load_data unchanged.
- Back-to-back: read addr 1 then write addr 2, each with immediate ack.
  - Expect: second bus_req asserted exactly 3 cycles after the first.
  - Expect: no duplicate transaction for addr 1.
- Timeout (TIMEOUT_CYC=4): read with no ack.
  - Expect: bus_req high 4 cycles, then DONE with load_data=0, load_valid=1 and bus_err=1.
  - Expect: bus_err remains 1 after a following successful read.
- Reset mid-REQ: rst=1 for 1 cycle on the second REQ cycle, with bus_ack=1 in the same cycle.
  - Expect: next cycle all outputs 0, FSM in IDLE, no load_valid.
- Both re and we with stray ack: re=we=1 → single write transaction, no load_valid.
  - Drive bus_ack=1 while in IDLE → no state change.
